// File: rtl/sd_controller_wb.sv
// Wishbone B3 classic slave register file for the SD card controller.
// Holds command / data-path / DMA configuration, exposes response and
// interrupt-status inputs for readback, and emits single-cycle strobes
// (command start, command/data interrupt clear) on the relevant writes.
//
// Handshake: a request is present while wb_cyc_i & wb_stb_i are high. The
// slave answers with a registered one-cycle wb_ack_o; the access (write
// update, read capture, strobe) happens on the edge that raises ack. A
// master that keeps the request asserted sees a fresh ack every second cycle.
module sd_controller_wb #(
    parameter int CMD_REG_SIZE      = 16,
    parameter int BLKSIZE_W         = 12,
    parameter int BLKCNT_W          = 16,
    parameter int INT_CMD_SIZE      = 5,
    parameter int INT_DATA_SIZE     = 3,
    parameter int RESET_BLOCK_SIZE  = 511,
    parameter int RESET_CLK_DIV     = 0,
    parameter int SUPPLY_VOLTAGE_mV = 3300
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [31:0]              wb_dat_i,
    output logic [31:0]              wb_dat_o,
    input  logic [7:0]               wb_adr_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic                     cmd_start,
    output logic                     data_int_rst,
    output logic                     cmd_int_rst,
    output logic [31:0]              argument_reg,
    output logic [CMD_REG_SIZE-1:0]  command_reg,
    input  logic [31:0]              response_0_reg,
    input  logic [31:0]              response_1_reg,
    input  logic [31:0]              response_2_reg,
    input  logic [31:0]              response_3_reg,
    output logic                     software_reset_reg,
    output logic [15:0]              timeout_reg,
    output logic [BLKSIZE_W-1:0]     block_size_reg,
    output logic                     controll_setting_reg,
    input  logic [INT_CMD_SIZE-1:0]  cmd_int_status_reg,
    output logic [INT_CMD_SIZE-1:0]  cmd_int_enable_reg,
    output logic [7:0]               clock_divider_reg,
    output logic [BLKCNT_W-1:0]      block_count_reg,
    output logic [31:0]              dma_addr_reg,
    input  logic [INT_DATA_SIZE-1:0] data_int_status_reg,
    output logic [INT_DATA_SIZE-1:0] data_int_enable_reg
);

    localparam logic [7:0] ADR_ARGUMENT   = 8'h00;
    localparam logic [7:0] ADR_COMMAND    = 8'h04;
    localparam logic [7:0] ADR_RESP0      = 8'h08;
    localparam logic [7:0] ADR_RESP1      = 8'h0C;
    localparam logic [7:0] ADR_RESP2      = 8'h10;
    localparam logic [7:0] ADR_RESP3      = 8'h14;
    localparam logic [7:0] ADR_CONTROLLER = 8'h1C;
    localparam logic [7:0] ADR_TIMEOUT    = 8'h20;
    localparam logic [7:0] ADR_CLOCK_D    = 8'h24;
    localparam logic [7:0] ADR_RESET      = 8'h28;
    localparam logic [7:0] ADR_VOLTAGE    = 8'h2C;
    localparam logic [7:0] ADR_CAPA       = 8'h30;
    localparam logic [7:0] ADR_CMD_ISR    = 8'h34;
    localparam logic [7:0] ADR_CMD_ISER   = 8'h38;
    localparam logic [7:0] ADR_DATA_ISR   = 8'h3C;
    localparam logic [7:0] ADR_DATA_ISER  = 8'h40;
    localparam logic [7:0] ADR_BLKSIZE    = 8'h44;
    localparam logic [7:0] ADR_BLKCNT     = 8'h48;
    localparam logic [7:0] ADR_DMA_ADDR   = 8'h60;

    logic        access;
    logic        wr_en;
    logic [31:0] byte_mask;
    logic [31:0] rd_data;

    // Accept a new request only when no ack is outstanding.
    assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_en     = access & wb_we_i;
    assign byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                        {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    // Handshake, read-data capture and single-cycle strobes.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= '0;
            cmd_start    <= 1'b0;
            cmd_int_rst  <= 1'b0;
            data_int_rst <= 1'b0;
        end else begin
            wb_ack_o     <= access;
            cmd_start    <= wr_en && (wb_adr_i == ADR_ARGUMENT);
            cmd_int_rst  <= wr_en && (wb_adr_i == ADR_CMD_ISR);
            data_int_rst <= wr_en && (wb_adr_i == ADR_DATA_ISR);
            if (access) begin
                wb_dat_o <= rd_data;
            end
        end
    end

    // Byte-lane gated register writes; RO and unmapped addresses fall through.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            argument_reg         <= '0;
            command_reg          <= '0;
            software_reset_reg   <= 1'b0;
            timeout_reg          <= '0;
            block_size_reg       <= BLKSIZE_W'(RESET_BLOCK_SIZE);
            controll_setting_reg <= 1'b0;
            cmd_int_enable_reg   <= '0;
            clock_divider_reg    <= 8'(RESET_CLK_DIV);
            block_count_reg      <= '0;
            dma_addr_reg         <= '0;
            data_int_enable_reg  <= '0;
        end else if (wr_en) begin
            case (wb_adr_i)
                ADR_ARGUMENT:   argument_reg <= (argument_reg & ~byte_mask)
                                              | (wb_dat_i & byte_mask);
                ADR_COMMAND:    command_reg <= (command_reg & ~byte_mask[CMD_REG_SIZE-1:0])
                                             | (wb_dat_i[CMD_REG_SIZE-1:0] & byte_mask[CMD_REG_SIZE-1:0]);
                ADR_CONTROLLER: if (wb_sel_i[0]) controll_setting_reg <= wb_dat_i[0];
                ADR_TIMEOUT:    timeout_reg <= (timeout_reg & ~byte_mask[15:0])
                                             | (wb_dat_i[15:0] & byte_mask[15:0]);
                ADR_CLOCK_D:    if (wb_sel_i[0]) clock_divider_reg <= wb_dat_i[7:0];
                ADR_RESET:      if (wb_sel_i[0]) software_reset_reg <= wb_dat_i[0];
                ADR_CMD_ISER:   if (wb_sel_i[0]) cmd_int_enable_reg <= wb_dat_i[INT_CMD_SIZE-1:0];
                ADR_DATA_ISER:  if (wb_sel_i[0]) data_int_enable_reg <= wb_dat_i[INT_DATA_SIZE-1:0];
                ADR_BLKSIZE:    block_size_reg <= (block_size_reg & ~byte_mask[BLKSIZE_W-1:0])
                                                | (wb_dat_i[BLKSIZE_W-1:0] & byte_mask[BLKSIZE_W-1:0]);
                ADR_BLKCNT:     block_count_reg <= (block_count_reg & ~byte_mask[BLKCNT_W-1:0])
                                                 | (wb_dat_i[BLKCNT_W-1:0] & byte_mask[BLKCNT_W-1:0]);
                ADR_DMA_ADDR:   dma_addr_reg <= (dma_addr_reg & ~byte_mask)
                                              | (wb_dat_i & byte_mask);
                default: ;
            endcase
        end
    end

    // Zero-extended read mux; unmapped addresses read as 0.
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            ADR_ARGUMENT:   rd_data = argument_reg;
            ADR_COMMAND:    rd_data[CMD_REG_SIZE-1:0] = command_reg;
            ADR_RESP0:      rd_data = response_0_reg;
            ADR_RESP1:      rd_data = response_1_reg;
            ADR_RESP2:      rd_data = response_2_reg;
            ADR_RESP3:      rd_data = response_3_reg;
            ADR_CONTROLLER: rd_data[0] = controll_setting_reg;
            ADR_TIMEOUT:    rd_data[15:0] = timeout_reg;
            ADR_CLOCK_D:    rd_data[7:0] = clock_divider_reg;
            ADR_RESET:      rd_data[0] = software_reset_reg;
            ADR_VOLTAGE:    rd_data = 32'(SUPPLY_VOLTAGE_mV);
            ADR_CAPA:       rd_data = '0;
            ADR_CMD_ISR:    rd_data[INT_CMD_SIZE-1:0] = cmd_int_status_reg;
            ADR_CMD_ISER:   rd_data[INT_CMD_SIZE-1:0] = cmd_int_enable_reg;
            ADR_DATA_ISR:   rd_data[INT_DATA_SIZE-1:0] = data_int_status_reg;
            ADR_DATA_ISER:  rd_data[INT_DATA_SIZE-1:0] = data_int_enable_reg;
            ADR_BLKSIZE:    rd_data[BLKSIZE_W-1:0] = block_size_reg;
            ADR_BLKCNT:     rd_data[BLKCNT_W-1:0] = block_count_reg;
            ADR_DMA_ADDR:   rd_data = dma_addr_reg;
            default:        rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_sd_controller_wb.sv
// Directed bench for sd_controller_wb: bus write/read drivers plus one task
// per feature, each with hand-computed expected values.
module tb_sd_controller_wb;

    logic        clk;
    logic        rst_n;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        cmd_start;
    logic        data_int_rst;
    logic        cmd_int_rst;
    logic [31:0] argument_reg;
    logic [15:0] command_reg;
    logic [31:0] resp0, resp1, resp2, resp3;
    logic        software_reset_reg;
    logic [15:0] timeout_reg;
    logic [11:0] block_size_reg;
    logic        controll_setting_reg;
    logic [4:0]  cmd_int_status;
    logic [4:0]  cmd_int_enable_reg;
    logic [7:0]  clock_divider_reg;
    logic [15:0] block_count_reg;
    logic [31:0] dma_addr_reg;
    logic [2:0]  data_int_status;
    logic [2:0]  data_int_enable_reg;

    int checks = 0;
    int errors = 0;

    sd_controller_wb dut (
        .wb_clk_i             (clk),
        .wb_rst_i             (rst_n),
        .wb_dat_i             (dat_i),
        .wb_dat_o             (dat_o),
        .wb_adr_i             (adr),
        .wb_sel_i             (sel),
        .wb_we_i              (we),
        .wb_cyc_i             (cyc),
        .wb_stb_i             (stb),
        .wb_ack_o             (ack),
        .cmd_start            (cmd_start),
        .data_int_rst         (data_int_rst),
        .cmd_int_rst          (cmd_int_rst),
        .argument_reg         (argument_reg),
        .command_reg          (command_reg),
        .response_0_reg       (resp0),
        .response_1_reg       (resp1),
        .response_2_reg       (resp2),
        .response_3_reg       (resp3),
        .software_reset_reg   (software_reset_reg),
        .timeout_reg          (timeout_reg),
        .block_size_reg       (block_size_reg),
        .controll_setting_reg (controll_setting_reg),
        .cmd_int_status_reg   (cmd_int_status),
        .cmd_int_enable_reg   (cmd_int_enable_reg),
        .clock_divider_reg    (clock_divider_reg),
        .block_count_reg      (block_count_reg),
        .dma_addr_reg         (dma_addr_reg),
        .data_int_status_reg  (data_int_status),
        .data_int_enable_reg  (data_int_enable_reg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: one write. pulses = {cmd_start, cmd_int_rst, data_int_rst}
    // sampled in the ack cycle and one cycle later.
    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [2:0] p_ack, output logic [2:0] p_after,
                            output logic ack_after);
        logic got;
        @(negedge clk);
        adr = a; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        p_ack = {cmd_start, cmd_int_rst, data_int_rst};
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        p_after   = {cmd_start, cmd_int_rst, data_int_rst};
        ack_after = ack;
        checks++;
        if (!got) begin
            $display("FAIL write_ack_timeout adr=%h: no ack within 8 cycles", a);
            errors++;
        end
    endtask

    // Driver: one read; returns captured data and pulses seen in the ack cycle.
    task automatic wb_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] p_ack);
        logic got;
        @(negedge clk);
        adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        d     = dat_o;
        p_ack = {cmd_start, cmd_int_rst, data_int_rst};
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        checks++;
        if (!got) begin
            $display("FAIL read_ack_timeout adr=%h: no ack within 8 cycles", a);
            errors++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [2:0]  p;
        rst_n = 1'b0;
        dat_i = '0; adr = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        resp0 = '0; resp1 = '0; resp2 = '0; resp3 = '0;
        cmd_int_status = '0; data_int_status = '0;
        repeat (2) @(negedge clk);
        checks++; if (ack !== 1'b0) begin $display("FAIL reset_ack got %b exp 0", ack); errors++; end
        checks++; if (dat_o !== 32'h0) begin $display("FAIL reset_dat_o got %h exp 0", dat_o); errors++; end
        checks++; if ({cmd_start, cmd_int_rst, data_int_rst} !== 3'b000) begin
            $display("FAIL reset_pulses got %b exp 000", {cmd_start, cmd_int_rst, data_int_rst}); errors++; end
        checks++; if ({argument_reg, command_reg, timeout_reg, block_count_reg, dma_addr_reg} !== 112'h0) begin
            $display("FAIL reset_rw_regs got %h exp 0", {argument_reg, command_reg, timeout_reg, block_count_reg, dma_addr_reg}); errors++; end
        checks++; if ({software_reset_reg, controll_setting_reg, cmd_int_enable_reg, data_int_enable_reg} !== 10'h0) begin
            $display("FAIL reset_small_regs got %h exp 0", {software_reset_reg, controll_setting_reg, cmd_int_enable_reg, data_int_enable_reg}); errors++; end
        checks++; if (block_size_reg !== 12'd511) begin $display("FAIL reset_block_size got %0d exp 511", block_size_reg); errors++; end
        checks++; if (clock_divider_reg !== 8'd0) begin $display("FAIL reset_clock_div got %0d exp 0", clock_divider_reg); errors++; end
        rst_n = 1'b1;
        @(negedge clk);
        wb_read(8'h2C, d, p);
        checks++; if (d !== 32'd3300) begin $display("FAIL voltage_read got %0d exp 3300", d); errors++; end
        wb_read(8'h30, d, p);
        checks++; if (d !== 32'd0) begin $display("FAIL capa_read got %h exp 0", d); errors++; end
    endtask

    task automatic test_argument();
        logic [2:0]  pa, pn;
        logic        aa;
        logic [31:0] d;
        wb_write(8'h00, 32'h01020304, 4'hF, pa, pn, aa);
        checks++; if (argument_reg !== 32'h01020304) begin $display("FAIL argument_reg got %h exp 01020304", argument_reg); errors++; end
        checks++; if (pa !== 3'b100) begin $display("FAIL cmd_start_pulse got %b exp 100", pa); errors++; end
        checks++; if (pn !== 3'b000) begin $display("FAIL cmd_start_one_cycle got %b exp 000", pn); errors++; end
        checks++; if (aa !== 1'b0) begin $display("FAIL ack_drop got %b exp 0", aa); errors++; end
        wb_read(8'h00, d, pa);
        checks++; if (d !== 32'h01020304) begin $display("FAIL argument_read got %h exp 01020304", d); errors++; end
        checks++; if (pa !== 3'b000) begin $display("FAIL read_no_pulse got %b exp 000", pa); errors++; end
    endtask

    task automatic test_config();
        logic [2:0] pa, pn;
        logic       aa;
        wb_write(8'h04, 32'h0405, 4'hF, pa, pn, aa);
        wb_write(8'h1C, 32'h1, 4'hF, pa, pn, aa);
        wb_write(8'h20, 32'h0B0C, 4'hF, pa, pn, aa);
        wb_write(8'h24, 32'h0D, 4'hF, pa, pn, aa);
        wb_write(8'h28, 32'h1, 4'hF, pa, pn, aa);
        checks++; if (pa !== 3'b000) begin $display("FAIL plain_write_no_pulse got %b exp 000", pa); errors++; end
        checks++; if (command_reg !== 16'h0405) begin $display("FAIL command_reg got %h exp 0405", command_reg); errors++; end
        checks++; if (controll_setting_reg !== 1'b1) begin $display("FAIL controller got %b exp 1", controll_setting_reg); errors++; end
        checks++; if (timeout_reg !== 16'h0B0C) begin $display("FAIL timeout_reg got %h exp 0b0c", timeout_reg); errors++; end
        checks++; if (clock_divider_reg !== 8'h0D) begin $display("FAIL clock_divider got %h exp 0d", clock_divider_reg); errors++; end
        checks++; if (software_reset_reg !== 1'b1) begin $display("FAIL software_reset got %b exp 1", software_reset_reg); errors++; end
    endtask

    task automatic test_byte_lanes();
        logic [2:0]  pa, pn;
        logic        aa;
        logic [31:0] d;
        wb_write(8'h00, 32'hFFFFFFFF, 4'b0010, pa, pn, aa);
        checks++; if (argument_reg !== 32'h0102FF04) begin $display("FAIL argument_lane1 got %h exp 0102ff04", argument_reg); errors++; end
        wb_write(8'h04, 32'hFFFF, 4'b0001, pa, pn, aa);
        checks++; if (command_reg !== 16'h04FF) begin $display("FAIL command_lane0 got %h exp 04ff", command_reg); errors++; end
        wb_write(8'h18, 32'hDEADBEEF, 4'hF, pa, pn, aa);
        wb_read(8'h18, d, pa);
        checks++; if (d !== 32'h0) begin $display("FAIL unmapped_read got %h exp 0", d); errors++; end
        wb_write(8'h2C, 32'h12345678, 4'hF, pa, pn, aa);
        wb_read(8'h2C, d, pa);
        checks++; if (d !== 32'd3300) begin $display("FAIL voltage_ro got %0d exp 3300", d); errors++; end
    endtask

    task automatic test_responses();
        logic [31:0] d;
        logic [2:0]  p;
        resp0 = 32'h04050607; resp1 = 32'h05060708; resp2 = 32'h06070809; resp3 = 32'h0708090A;
        wb_read(8'h08, d, p);
        checks++; if (d !== 32'h04050607) begin $display("FAIL resp0 got %h exp 04050607", d); errors++; end
        wb_read(8'h0C, d, p);
        checks++; if (d !== 32'h05060708) begin $display("FAIL resp1 got %h exp 05060708", d); errors++; end
        wb_read(8'h10, d, p);
        checks++; if (d !== 32'h06070809) begin $display("FAIL resp2 got %h exp 06070809", d); errors++; end
        wb_read(8'h14, d, p);
        checks++; if (d !== 32'h0708090A) begin $display("FAIL resp3 got %h exp 0708090a", d); errors++; end
    endtask

    task automatic test_interrupts();
        logic [2:0]  pa, pn;
        logic        aa;
        logic [31:0] d;
        wb_write(8'h34, 32'h0, 4'hF, pa, pn, aa);
        checks++; if (pa !== 3'b010) begin $display("FAIL cmd_int_rst_pulse got %b exp 010", pa); errors++; end
        checks++; if (pn !== 3'b000) begin $display("FAIL cmd_int_rst_one_cycle got %b exp 000", pn); errors++; end
        wb_write(8'h3C, 32'hFFFFFFFF, 4'hF, pa, pn, aa);
        checks++; if (pa !== 3'b001) begin $display("FAIL data_int_rst_pulse got %b exp 001", pa); errors++; end
        checks++; if (pn !== 3'b000) begin $display("FAIL data_int_rst_one_cycle got %b exp 000", pn); errors++; end
        cmd_int_status = 5'h1A; data_int_status = 3'h6;
        wb_read(8'h34, d, pa);
        checks++; if (d !== 32'h1A) begin $display("FAIL cmd_isr_read got %h exp 1a", d); errors++; end
        wb_read(8'h3C, d, pa);
        checks++; if (d !== 32'h6) begin $display("FAIL data_isr_read got %h exp 6", d); errors++; end
        wb_write(8'h38, 32'h15, 4'hF, pa, pn, aa);
        wb_write(8'h40, 32'h5, 4'hF, pa, pn, aa);
        checks++; if (cmd_int_enable_reg !== 5'h15) begin $display("FAIL cmd_iser got %h exp 15", cmd_int_enable_reg); errors++; end
        checks++; if (data_int_enable_reg !== 3'h5) begin $display("FAIL data_iser got %h exp 5", data_int_enable_reg); errors++; end
    endtask

    task automatic test_data_path();
        logic [2:0]  pa, pn;
        logic        aa;
        logic [31:0] d;
        wb_write(8'h44, 32'hABC, 4'hF, pa, pn, aa);
        wb_write(8'h48, 32'h1011, 4'hF, pa, pn, aa);
        wb_write(8'h60, 32'h11121314, 4'hF, pa, pn, aa);
        checks++; if (block_size_reg !== 12'hABC) begin $display("FAIL block_size got %h exp abc", block_size_reg); errors++; end
        checks++; if (block_count_reg !== 16'h1011) begin $display("FAIL block_count got %h exp 1011", block_count_reg); errors++; end
        checks++; if (dma_addr_reg !== 32'h11121314) begin $display("FAIL dma_addr got %h exp 11121314", dma_addr_reg); errors++; end
        wb_read(8'h44, d, pa);
        checks++; if (d !== 32'hABC) begin $display("FAIL block_size_read got %h exp abc", d); errors++; end
        wb_read(8'h48, d, pa);
        checks++; if (d !== 32'h1011) begin $display("FAIL block_count_read got %h exp 1011", d); errors++; end
        wb_read(8'h60, d, pa);
        checks++; if (d !== 32'h11121314) begin $display("FAIL dma_addr_read got %h exp 11121314", d); errors++; end
    endtask

    // Request held high: ack pattern must be 1,0,1,0 with voltage data on acks.
    task automatic test_back_to_back();
        logic [3:0]  seen;
        logic [31:0] d;
        @(negedge clk);
        adr = 8'h2C; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen[3-i] = ack;
            if (i == 2) d = dat_o;
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        checks++; if (seen !== 4'b1010) begin $display("FAIL held_ack_pattern got %b exp 1010", seen); errors++; end
        checks++; if (d !== 32'd3300) begin $display("FAIL held_read_data got %0d exp 3300", d); errors++; end
    endtask

    // Reset asserted while ack and cmd_start are high must clear them at once.
    task automatic test_reset_abort();
        @(negedge clk);
        adr = 8'h00; dat_i = 32'hCAFEF00D; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #2;
        checks++; if ({ack, cmd_start} !== 2'b11) begin $display("FAIL abort_pre got %b exp 11", {ack, cmd_start}); errors++; end
        rst_n = 1'b0;
        #1;
        checks++; if ({ack, cmd_start} !== 2'b00) begin $display("FAIL abort_ack_pulse got %b exp 00", {ack, cmd_start}); errors++; end
        checks++; if (argument_reg !== 32'h0) begin $display("FAIL abort_argument got %h exp 0", argument_reg); errors++; end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_argument();
        test_config();
        test_byte_lanes();
        test_responses();
        test_interrupts();
        test_data_path();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
